// File: rtl/debounce_bank_pkg.sv
// debounce_bank_pkg: board timing defaults and width helpers for the button conditioner.
package debounce_bank_pkg;

    // 100 MHz board: 10 ms stable, 250 ms hold, 50 ms repeat
    localparam int DEF_STABLE_CYCLES = 1_000_000;
    localparam int DEF_HOLD_CYCLES   = 25_000_000;
    localparam int DEF_REPEAT_CYCLES = 5_000_000;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one button channel -- synchroniser, stability filter, hold/repeat timer
// and registered level/pulse outputs.
module debounce_chan
    import debounce_bank_pkg::*;
#(
    parameter int STABLE_CYCLES = 262144,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic release_p,
    output logic long_press,
    output logic repeat_p,
    output logic held,
    output logic press_nxt
);

    localparam int CW = clog2(STABLE_CYCLES) + 1;
    localparam int TW = clog2(imax(HOLD_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit REP_EN = REPEAT_CYCLES > 0;

    logic          s1_q, s1_d, s2_q, s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          level_q, level_d, held_q, held_d;
    logic          press_q, press_d, release_q, release_d;
    logic          long_q, long_d, repeat_q, repeat_d;
    logic          flip, hold_hit, rep_hit;

    always_comb begin
        s1_d      = btn_raw ^ ACTIVE_LOW;
        s2_d      = s1_q;
        flip      = (s2_q != level_q) && (cnt_q == CNT_LAST);
        cnt_d     = (s2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
        level_d   = flip ? s2_q : level_q;
        press_d   = flip && s2_q;
        release_d = flip && !s2_q;
        // an accepted release cancels any long/repeat pulse due on the same edge
        hold_hit  = level_q && !release_d && !held_q && (tmr_q == HOLD_LAST);
        rep_hit   = level_q && !release_d && held_q && REP_EN && (tmr_q == REP_LAST);
        tmr_d     = (!level_q || release_d || hold_hit || rep_hit) ? '0 :
                    (held_q && !REP_EN) ? tmr_q : tmr_q + 1'b1;
        held_d    = release_d ? 1'b0 : hold_hit ? 1'b1 : held_q;
        long_d    = hold_hit;
        repeat_d  = press_d || hold_hit || rep_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            level_q   <= 1'b0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            level_q   <= level_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level      = level_q;
    assign press      = press_q;
    assign release_p  = release_q;
    assign long_press = long_q;
    assign repeat_p   = repeat_q;
    assign held       = held_q;
    assign press_nxt  = press_d;

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N independent debounced button channels with press/release/long/repeat
// pulses and a registered any-press flag.
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 262144,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_p,
    output logic [N_CH-1:0] held,
    output logic            any_press
);

    logic [N_CH-1:0] press_nxt;
    logic            any_press_q, any_press_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (btn_raw[g]),
            .level     (level[g]),
            .press     (press[g]),
            .release_p (release_p[g]),
            .long_press(long_press[g]),
            .repeat_p  (repeat_p[g]),
            .held      (held[g]),
            .press_nxt (press_nxt[g])
        );
    end

    // built from next-cycle press so it lands on the same edge as press
    always_comb any_press_d = |press_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) any_press_q <= 1'b0;
        else     any_press_q <= any_press_d;
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed stimulus with a pulse scoreboard; a monitor pops the expected
// event whenever the DUT shows any pulse and flags missing or unexpected ones.
module tb_debounce_bank;

    typedef struct packed {
        int         c;
        logic [1:0] pr, rl, lg, rp, hd, lv;
        logic       an;
    } ev_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [1:0] btn = 2'b00;
    logic [1:0] level, press, release_p, long_press, repeat_p, held;
    logic       any_press;
    logic [1:0] level2, press2, release2, long2, repeat2, held2;
    logic       any2;
    int         cyc, n_chk = 0, n_fail = 0, n_rep2 = 0, n_long2 = 0;
    int         t, r0, l0;
    ev_t        q[$];
    ev_t        act, exp_e;

    always #5 clk = ~clk;

    debounce_bank #(.N_CH(2), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn), .level(level), .press(press),
        .release_p(release_p), .long_press(long_press), .repeat_p(repeat_p),
        .held(held), .any_press(any_press));

    debounce_bank #(.N_CH(2), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(0)) dut_norep (
        .clk(clk), .rst(rst), .btn_raw(btn), .level(level2), .press(press2),
        .release_p(release2), .long_press(long2), .repeat_p(repeat2),
        .held(held2), .any_press(any2));

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (repeat2[0]) n_rep2++;
            if (long2[0])   n_long2++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            act = '{cyc, press, release_p, long_press, repeat_p, held, level, any_press};
            if ((press | release_p | long_press | repeat_p) != 2'b00 || any_press) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse cyc=%0d pr=%b rl=%b lg=%b rp=%b hd=%b lv=%b an=%b",
                             cyc, press, release_p, long_press, repeat_p, held, level, any_press);
                end else begin
                    exp_e = q.pop_front();
                    if (act !== exp_e) begin
                        n_fail++;
                        $display("FAIL event got cyc=%0d pr=%b rl=%b lg=%b rp=%b hd=%b lv=%b an=%b want cyc=%0d pr=%b rl=%b lg=%b rp=%b hd=%b lv=%b an=%b",
                                 act.c, act.pr, act.rl, act.lg, act.rp, act.hd, act.lv, act.an,
                                 exp_e.c, exp_e.pr, exp_e.rl, exp_e.lg, exp_e.rp, exp_e.hd, exp_e.lv, exp_e.an);
                    end
                end
            end else if (q.size() > 0 && q[0].c < cyc) begin
                n_chk++;
                n_fail++;
                exp_e = q.pop_front();
                $display("FAIL missed_event at cyc=%0d, expected at cyc=%0d pr=%b rl=%b lg=%b rp=%b",
                         cyc, exp_e.c, exp_e.pr, exp_e.rl, exp_e.lg, exp_e.rp);
            end
        end
    end

    task automatic expect_ev(input int c, input logic [1:0] pr, rl, lg, rp, hd, lv);
        q.push_back('{c, pr, rl, lg, rp, hd, lv, |pr});
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", 32'({level, press, release_p, long_press, repeat_p, held, any_press}), 32'd0);
        // press ch0, hold through long press and repeats, release on a repeat slot
        t  = 2;
        to_cyc(t);
        r0 = n_rep2;
        l0 = n_long2;
        btn = 2'b01;
        expect_ev(t + 6,  2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        expect_ev(t + 16, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01);
        expect_ev(t + 19, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
        expect_ev(t + 22, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
        expect_ev(t + 25, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
        to_cyc(t + 25);
        btn = 2'b00;
        expect_ev(t + 28, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
        expect_ev(t + 31, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        to_cyc(t + 40);
        check("norep_repeat_count", 32'(n_rep2 - r0), 32'd2);
        check("norep_long_count", 32'(n_long2 - l0), 32'd1);
        // bounce then settle high, release before hold expires
        t = 50;
        to_cyc(t);
        btn = 2'b01;
        to_cyc(t + 2);
        btn = 2'b00;
        to_cyc(t + 4);
        btn = 2'b01;
        to_cyc(t + 6);
        btn = 2'b00;
        to_cyc(t + 8);
        btn = 2'b01;
        expect_ev(t + 14, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        to_cyc(t + 16);
        btn = 2'b00;
        expect_ev(t + 22, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        // both channels on the same cycle
        t = 80;
        to_cyc(t);
        btn = 2'b11;
        expect_ev(t + 6, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11);
        to_cyc(t + 7);
        btn = 2'b00;
        expect_ev(t + 13, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        // async reset while held, key kept down through reset
        t = 100;
        to_cyc(t);
        btn = 2'b01;
        expect_ev(t + 6,  2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        expect_ev(t + 16, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01);
        to_cyc(t + 17);
        check("held_before_reset", 32'(held), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("async_reset_outputs", 32'({level, press, release_p, long_press, repeat_p, held, any_press}), 32'd0);
        check("queue_drained_at_reset", 32'(q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_ev(6, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        to_cyc(8);
        btn = 2'b00;
        expect_ev(14, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        to_cyc(20);
        check("queue_empty_at_end", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
